// File: rtl/dmem_pkg.sv
// Shared constants for the RV32I data memory.
// Strobe encodings and default widths.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 7;
    localparam int DMEM_DATA_W = 32;

    localparam logic [2:0] STRB_WORD      = 3'b000;
    localparam logic [2:0] STRB_HALF_LO   = 3'b001;
    localparam logic [2:0] STRB_HALF_HI   = 3'b011;
    localparam logic [2:0] STRB_BYTE_BASE = 3'b100;

endpackage

// File: rtl/data_memory_if.sv
// Read/write port bundle for the data memory.
// The datapath is master, the memory is slave.
interface data_memory_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] rd_addr0;
    logic [DATA_W-1:0] rd_dout0;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [DATA_W-1:0] wr_din0;
    logic [2:0]        wr_strb;

    modport master (
        output rd_addr0,
        input  rd_dout0,
        output we0,
        output wr_addr0,
        output wr_din0,
        output wr_strb
    );

    modport slave (
        input  rd_addr0,
        output rd_dout0,
        input  we0,
        input  wr_addr0,
        input  wr_din0,
        input  wr_strb
    );

endinterface

// File: rtl/dmem_lane_decode.sv
// Turns the store strobe code into a byte-lane mask and
// lane-aligned write data (low din bits replicated per lane).
module dmem_lane_decode
    import dmem_pkg::*;
(
    input  logic [2:0]  wr_strb,
    input  logic [31:0] wr_din0,
    output logic [3:0]  lane_en,
    output logic [31:0] lane_data
);

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = '0;
        unique case (1'b1)
            wr_strb[2]: begin
                lane_en   = 4'b0001 << wr_strb[1:0];
                lane_data = {4{wr_din0[7:0]}};
            end
            (wr_strb == STRB_WORD): begin
                lane_en   = 4'b1111;
                lane_data = wr_din0;
            end
            (wr_strb == STRB_HALF_LO): begin
                lane_en   = 4'b0011;
                lane_data = {2{wr_din0[15:0]}};
            end
            (wr_strb == STRB_HALF_HI): begin
                lane_en   = 4'b1100;
                lane_data = {2{wr_din0[15:0]}};
            end
            // 3'b010 is reserved: no lanes enabled
            default: begin
                lane_en   = 4'b0000;
                lane_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised RV32I data memory: combinational read,
// byte-lane write on rising clk, async active-low clear.
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_if.slave      bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        lane_en;
    logic [31:0]       lane_data;

    dmem_lane_decode u_lane_decode (
        .wr_strb   (bus.wr_strb),
        .wr_din0   (bus.wr_din0),
        .lane_en   (lane_en),
        .lane_data (lane_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.we0) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) begin
                    mem[bus.wr_addr0][8*l +: 8] <= lane_data[8*l +: 8];
                end
            end
        end
    end

    assign bus.rd_dout0 = mem[bus.rd_addr0];

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed plan
// plus randomized stores against a word-array model.
module tb_data_memory;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    data_memory_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    data_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] model [128];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Store semantics from the ISA view: which bytes change and with what.
    function automatic logic [31:0] store(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [2:0]  s);
        int unsigned k;
        logic [31:0] m;
        if (s == 3'd0) return din;
        if (s == 3'd1) return (old & 32'hFFFF0000) | (din & 32'h0000FFFF);
        if (s == 3'd3) return (old & 32'h0000FFFF) | ((din & 32'hFFFF) << 16);
        if (s == 3'd2) return old;
        k = 32'(s) - 4;
        m = 32'hFF << (8 * k);
        return (old & ~m) | ((din & 32'hFF) << (8 * k));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 128; i++) model[i] = '0;
    endtask

    task automatic wr(input logic [6:0]  a,
                      input logic [31:0] d,
                      input logic [2:0]  s,
                      input logic        we);
        @(negedge clk);
        bus.wr_addr0 = a;
        bus.wr_din0  = d;
        bus.wr_strb  = s;
        bus.we0      = we;
        @(posedge clk);
        if (we) model[a] = store(model[a], d, s);
        #1;
        bus.we0 = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [6:0] a);
        bus.rd_addr0 = a;
        #1;
        check(tag, bus.rd_dout0, model[a]);
    endtask

    task automatic rd_exp(input string tag,
                          input logic [6:0]  a,
                          input logic [31:0] exp);
        bus.rd_addr0 = a;
        #1;
        check(tag, bus.rd_dout0, exp);
    endtask

    initial begin
        bus.rd_addr0 = '0;
        bus.we0      = 1'b0;
        bus.wr_addr0 = '0;
        bus.wr_din0  = '0;
        bus.wr_strb  = '0;
        model_clear();

        #2;
        rd_exp("rst_a0", 7'd0, 32'h0);
        rd_exp("rst_a127", 7'd127, 32'h0);
        #9 rst = 1'b1;

        // 1: async reset, with a write pending across the edge
        wr(7'd5, 32'hDEADBEEF, STRB_WORD, 1'b1);
        rd_exp("t1_pre", 7'd5, 32'hDEADBEEF);
        @(negedge clk);
        #2;
        bus.wr_addr0 = 7'd5;
        bus.wr_din0  = 32'h55555555;
        bus.wr_strb  = STRB_WORD;
        bus.we0      = 1'b1;
        rst = 1'b0;
        model_clear();
        rd_exp("t1_async", 7'd5, 32'h0);
        @(posedge clk);
        #1;
        rd_exp("t1_prio", 7'd5, 32'h0);
        bus.we0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 2: word store
        wr(7'd3, 32'h12345678, STRB_WORD, 1'b1);
        rd_exp("t2_w3", 7'd3, 32'h12345678);
        rd_exp("t2_w2", 7'd2, 32'h0);
        rd_exp("t2_w4", 7'd4, 32'h0);

        // 3: half stores
        wr(7'd7, 32'hAAAAAAAA, STRB_WORD, 1'b1);
        wr(7'd7, 32'hFFFF1234, STRB_HALF_LO, 1'b1);
        rd_exp("t3_lo", 7'd7, 32'hAAAA1234);
        wr(7'd7, 32'h00005678, STRB_HALF_HI, 1'b1);
        rd_exp("t3_hi", 7'd7, 32'h56781234);

        // 4: byte stores, junk in upper din bits
        wr(7'd9, 32'h0, STRB_WORD, 1'b1);
        wr(7'd9, 32'hFFFFFF11, 3'b100, 1'b1);
        rd_exp("t4_b0", 7'd9, 32'h00000011);
        wr(7'd9, 32'hABCDEF22, 3'b101, 1'b1);
        wr(7'd9, 32'h99999933, 3'b110, 1'b1);
        rd_exp("t4_b2", 7'd9, 32'h00332211);
        wr(7'd9, 32'h12345644, 3'b111, 1'b1);
        rd_exp("t4_all", 7'd9, 32'h44332211);

        // 5: write disabled and reserved code
        wr(7'd1, 32'hCAFEF00D, STRB_WORD, 1'b1);
        wr(7'd1, 32'h0, STRB_WORD, 1'b0);
        rd_exp("t5_we0", 7'd1, 32'hCAFEF00D);
        wr(7'd1, 32'h0, 3'b010, 1'b1);
        rd_exp("t5_rsvd", 7'd1, 32'hCAFEF00D);

        // 6: read-during-write at top address, bottom untouched
        wr(7'd0, 32'h13572468, STRB_WORD, 1'b1);
        wr(7'd127, 32'h76543210, STRB_WORD, 1'b1);
        @(negedge clk);
        bus.rd_addr0 = 7'd127;
        bus.wr_addr0 = 7'd127;
        bus.wr_din0  = 32'h0BADC0DE;
        bus.wr_strb  = STRB_WORD;
        bus.we0      = 1'b1;
        #1;
        check("t6_old", bus.rd_dout0, 32'h76543210);
        @(posedge clk);
        model[127] = 32'h0BADC0DE;
        #1;
        bus.we0 = 1'b0;
        check("t6_new", bus.rd_dout0, 32'h0BADC0DE);
        rd_exp("t6_w0", 7'd0, 32'h13572468);

        // randomized stores checked against the model
        for (int n = 0; n < 600; n++) begin
            logic [6:0]  a;
            logic [31:0] d;
            logic [2:0]  s;
            logic        we;
            a  = 7'($urandom_range(0, 127));
            d  = $urandom;
            s  = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 3) != 0);
            wr(a, d, s, we);
            rd("rnd_wr", a);
            rd("rnd_any", 7'($urandom_range(0, 127)));
        end

        for (int i = 0; i < 128; i++) rd("sweep", 7'(i));

        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < 128; i += 17) rd("final_rst", 7'(i));
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
